regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_rd_port.sv | 61 ++++++
 rtl/regfile_mp.sv | 114 +++++++++++
 tb/tb_regfile_mp.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the multi-port register file.
//   rf_state_e  : sweep FSM state (CLEAR / READY)
//   DEF_XLEN    : default register width
//   DEF_NREGS   : default register count
//   rf_addr_w() : address width for a given register count
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

    function automatic int rf_addr_w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port of regfile_mp.
//   clk, rst     : clock, async active-low reset
//   en           : array usable (READY); when low the output reads zero
//   ra           : read address
//   arr_q        : current array contents at ra
//   wen0/wa0/wd0 : qualified write port 0 (for forwarding)
//   wen1/wa1/wd1 : qualified write port 1 (for forwarding, wins over port 0)
//   rd           : read data, one cycle after the address
// Build option: REGFILE_MP_BYPASS_EN enables write-to-read forwarding.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [AW-1:0]   ra,
    input  logic [XLEN-1:0] arr_q,
    input  logic            wen0,
    input  logic [AW-1:0]   wa0,
    input  logic [XLEN-1:0] wd0,
    input  logic            wen1,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd1,
    output logic [XLEN-1:0] rd
);

    logic [XLEN-1:0] rd_d;
    logic [XLEN-1:0] rd_q;

    always_comb begin
        rd_d = arr_q;
`ifdef REGFILE_MP_BYPASS_EN
        // Write enables arrive already gated against address 0 and CLEAR.
        if (wen1 && (wa1 == ra))
            rd_d = wd1;
        else if (wen0 && (wa0 == ra))
            rd_d = wd0;
`endif
        if (!en || (ra == '0))
            rd_d = '0;
    end

`ifndef REGFILE_MP_BYPASS_EN
    logic unused_fwd;
    assign unused_fwd = ^{wen0, wa0, wd0, wen1, wa1, wd1};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rd_q <= '0;
        else
            rd_q <= rd_d;
    end

    // Mask so the first sweep cycle does not show the last READY read.
    assign rd = en ? rd_q : '0;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NREGS x XLEN register file, two write ports, NRD registered
// read ports, and a self-clearing sweep after reset or a clr pulse.
//   clk, rst     : clock (rising), async active-low reset
//   clr          : soft-clear pulse (honoured only in READY)
//   ready        : sweep done, array usable
//   we0/wa0/wd0  : write port 0
//   we1/wa1/wd1  : write port 1 (wins on same-address collision)
//   ra           : packed read addresses, port k in slice k
//   rd           : packed read data, port k in slice k, one-cycle latency
// Build option: REGFILE_MP_BYPASS_EN enables write-to-read forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr,
    output logic                            ready,
    input  logic                            we0,
    input  logic                            we1,
    input  logic [rf_addr_w(NREGS)-1:0]     wa0,
    input  logic [rf_addr_w(NREGS)-1:0]     wa1,
    input  logic [XLEN-1:0]                 wd0,
    input  logic [XLEN-1:0]                 wd1,
    input  logic [NRD*rf_addr_w(NREGS)-1:0] ra,
    output logic [NRD*XLEN-1:0]             rd
);

    localparam int AW = rf_addr_w(NREGS);

    rf_state_e     state;
    rf_state_e     state_nxt;
    logic [AW-1:0] ptr;
    logic          sweep_last;
    logic          sweep_we;
    logic          wen0;
    logic          wen1;

    assign sweep_last = (ptr == AW'(NREGS - 1));

    // State register; ptr parks at 1 outside the sweep so a new sweep
    // always starts there (entry 0 is never stored, it reads as zero).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CLEAR;
            ptr   <= AW'(1);
        end else begin
            state <= state_nxt;
            if (state == CLEAR && !sweep_last)
                ptr <= ptr + AW'(1);
            else
                ptr <= AW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (sweep_last) state_nxt = READY;
            READY:   if (clr)        state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        ready    = (state == READY);
        sweep_we = (state == CLEAR);
    end

    assign wen0 = ready && we0 && (wa0 != '0);
    assign wen1 = ready && we1 && (wa1 != '0);

    // Storage has no reset so it can map onto RAM; the sweep zeroes it.
    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[ptr] <= '0;
        end else begin
            if (wen0) mem[wa0] <= wd0;
            if (wen1) mem[wa1] <= wd1;   // later assignment: port 1 wins
        end
    end

    logic [NRD-1:0][AW-1:0]   ra_v;
    logic [NRD-1:0][XLEN-1:0] rd_v;

    assign ra_v = ra;
    assign rd   = rd_v;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_rd_port #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_rd (
            .clk   (clk),
            .rst   (rst),
            .en    (ready),
            .ra    (ra_v[k]),
            .arr_q (mem[ra_v[k]]),
            .wen0  (wen0),
            .wa0   (wa0),
            .wd0   (wd0),
            .wen1  (wen1),
            .wa1   (wa1),
            .wd1   (wd1),
            .rd    (rd_v[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp. The driver computes the
// expected post-edge outputs from an array model and queues them; a monitor
// on the falling edge pops and compares.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 clr = 1'b0;
    logic                 ready;
    logic                 we0 = 1'b0;
    logic                 we1 = 1'b0;
    logic [AW-1:0]        wa0 = '0;
    logic [AW-1:0]        wa1 = '0;
    logic [XLEN-1:0]      wd0 = '0;
    logic [XLEN-1:0]      wd1 = '0;
    logic [NRD*AW-1:0]    ra  = '0;
    logic [NRD*XLEN-1:0]  rd;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .ready (ready),
        .we0   (we0),
        .we1   (we1),
        .wa0   (wa0),
        .wa1   (wa1),
        .wd0   (wd0),
        .wd1   (wd1),
        .ra    (ra),
        .rd    (rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                rdy;
        logic [NRD*XLEN-1:0] data;
        string               tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: plain array plus "cycles left in sweep".
    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_ready;
    int              m_rem;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            vectors++;
            if (ready !== mon_e.rdy || rd !== mon_e.data) begin
                miscompares++;
                $display("FAIL %s: got ready=%0b rd=%h, want ready=%0b rd=%h",
                         mon_e.tag, ready, rd, mon_e.rdy, mon_e.data);
            end
        end
    end

    task automatic do_reset(input string tag);
        exp_t e;
        @(negedge clk);
        #1;
        rst = 1'b0; clr = 1'b0; we0 = 1'b0; we1 = 1'b0;
        m_ready = 1'b0;
        m_rem   = NREGS - 1;
        foreach (m_mem[i]) m_mem[i] = '0;
        e.rdy = 1'b0; e.data = '0; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(input string tag, input bit c,
                        input bit w0, input int a0, input logic [XLEN-1:0] d0,
                        input bit w1, input int a1, input logic [XLEN-1:0] d1,
                        input int r0, input int r1);
        logic [XLEN-1:0] nm [NREGS];
        int   ras [NRD];
        exp_t e;
        @(negedge clk);
        #1;
        rst = 1'b1; clr = c;
        we0 = w0; wa0 = AW'(a0); wd0 = d0;
        we1 = w1; wa1 = AW'(a1); wd1 = d1;
        ra  = {AW'(r1), AW'(r0)};
        ras[0] = r0; ras[1] = r1;
        e.tag = tag; e.data = '0;
        if (!m_ready) begin
            m_rem--;
            if (m_rem == 0) m_ready = 1'b1;
            e.rdy = m_ready;
        end else if (c) begin
            m_ready = 1'b0;
            m_rem   = NREGS - 1;
            foreach (m_mem[i]) m_mem[i] = '0;
            e.rdy = 1'b0;
        end else begin
            nm = m_mem;
            if (w0 && a0 != 0) nm[a0] = d0;
            if (w1 && a1 != 0) nm[a1] = d1;
            for (int k = 0; k < NRD; k++) begin
`ifdef REGFILE_MP_BYPASS_EN
                e.data[k*XLEN +: XLEN] = nm[ras[k]];
`else
                e.data[k*XLEN +: XLEN] = m_mem[ras[k]];
`endif
            end
            m_mem = nm;
            e.rdy = 1'b1;
        end
        sb.push_back(e);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, '0, 0, 0, '0, 0, 0);
    endtask

    task automatic rd2(input string tag, input int r0, input int r1);
        step(tag, 0, 0, 0, '0, 0, 0, '0, r0, r1);
    endtask

    initial begin
        do_reset("reset");
        for (int i = 0; i < NREGS - 1; i++) idle("sweep_after_reset");
        for (int a = 0; a < NREGS; a++) rd2("read_zero_all", a, NREGS - 1 - a);

        step("wr_x5", 0, 1, 5, 32'hDEADBEEF, 0, 0, '0, 0, 0);
        rd2("rd_x5", 5, 0);
        idle("rd_x5_out");

        step("wr_x7_both", 0, 1, 7, 32'h1, 1, 7, 32'h2, 0, 0);
        rd2("rd_x7", 7, 7);
        idle("rd_x7_out");

        step("wr_x0", 0, 1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0, 0);
        rd2("rd_x0", 0, 0);
        step("wr_x0_rd_x0", 0, 1, 0, 32'hFFFFFFFF, 0, 0, '0, 0, 0);

        step("wr_x9_a", 0, 1, 9, 32'hA, 0, 0, '0, 0, 0);
        step("wr_x9_b_rd", 0, 1, 9, 32'hB, 0, 0, '0, 0, 9);
        step("fwd_priority", 0, 1, 11, 32'h111, 1, 11, 32'h222, 11, 11);
        rd2("rd_x9_x11", 9, 11);

        step("wr_x3", 0, 1, 3, 32'h55, 0, 0, '0, 0, 0);
        rd2("rd_x3", 3, 3);
        step("clr_pulse", 1, 0, 0, '0, 0, 0, '0, 3, 3);
        for (int i = 0; i < 10; i++)
            step("sweep_ignore", (i == 4), 1, 3, 32'h77, 1, 3, 32'h99, 3, 3);
        do_reset("reset_mid_sweep");
        for (int i = 0; i < NREGS - 1; i++) rd2("sweep_restart", 3, 5);
        rd2("rd_x3_cleared", 3, 5);

        for (int n = 0; n < 400; n++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            step("random",
                 ($urandom_range(0, 59) == 0),
                 $urandom_range(0, 1) == 1,
                 narrow ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1),
                 $urandom,
                 $urandom_range(0, 1) == 1,
                 narrow ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1),
                 $urandom,
                 narrow ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1),
                 narrow ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1));
        end
        idle("tail");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
